// File: rtl/out_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : out_fsm
//  Brief    : MII transmit output state machine. Serialises a buffered frame
//             as preamble, SFD, payload nibbles (low nibble first) and an
//             inter-frame gap, while addressing the upstream frame buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module out_fsm #(
  parameter int         PRE_NIBBLES = 15,
  parameter logic [3:0] SFD_NIBBLE  = 4'hD,
  parameter int         IFG_CYCLES  = 24
) (
  input  logic        clk_phy,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic [23:0] ctrl_block_in,
  output logic [11:0] frame_seq_out,
  output logic        xmit_done_out,
  output logic [3:0]  data_out
);

  // One shared cycle counter serves both the preamble and the gap phases.
  localparam int               CNT_MAX    = (PRE_NIBBLES > IFG_CYCLES) ? PRE_NIBBLES : IFG_CYCLES;
  localparam int               CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_NIBBLES);
  localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRST  = CNT_W'(1);
  localparam logic [3:0]       PRE_NIBBLE = 4'h5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE     = 3'd1,
    SFD     = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4,
    IFG     = 3'd5
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      len_reg;
  logic [11:0]      bytes_sent;
  logic [7:0]       byte_reg;

  logic [11:0]      seq_last;
  logic             seq_can_adv;
  logic [11:0]      seq_next;
  logic             more_bytes;

  // Buffer address saturates on the last byte of the frame instead of wrapping.
  assign seq_last    = len_reg - 12'd1;
  assign seq_can_adv = (frame_seq_out < seq_last);
  assign seq_next    = seq_can_adv ? (frame_seq_out + 12'd1) : frame_seq_out;
  assign more_bytes  = (bytes_sent < len_reg);

  // Frame sequencer: every output is produced from the state being entered, so
  // data_out always shows the nibble belonging to the current state.
  always_ff @(posedge clk_phy) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      len_reg       <= 12'd0;
      bytes_sent    <= 12'd0;
      byte_reg      <= 8'd0;
      frame_seq_out <= 12'd0;
      xmit_done_out <= 1'b0;
      data_out      <= 4'd0;
    end else begin
      xmit_done_out <= 1'b0;
      case (state)
        IDLE: begin
          data_out      <= 4'd0;
          frame_seq_out <= 12'd0;
          if (ctrl_block_in[11:0] != 12'd0) begin
            // Upper descriptor bits are reserved and deliberately dropped.
            len_reg    <= ctrl_block_in[11:0];
            bytes_sent <= 12'd0;
            cnt        <= CNT_FIRST;
            data_out   <= PRE_NIBBLE;
            state      <= PRE;
          end
        end

        PRE: begin
          if (cnt == PRE_LAST) begin
            data_out <= SFD_NIBBLE;
            state    <= SFD;
          end else begin
            cnt      <= cnt + 1'b1;
            data_out <= PRE_NIBBLE;
          end
        end

        SFD: begin
          // Address 0 has been presented since IDLE, so byte 0 is valid here.
          byte_reg      <= data_in;
          data_out      <= data_in[3:0];
          frame_seq_out <= seq_next;
          bytes_sent    <= 12'd1;
          state         <= DATA_LO;
        end

        DATA_LO: begin
          data_out <= byte_reg[7:4];
          state    <= DATA_HI;
        end

        DATA_HI: begin
          if (more_bytes) begin
            // The address moved two edges ago, leaving time for a registered buffer.
            byte_reg      <= data_in;
            data_out      <= data_in[3:0];
            frame_seq_out <= seq_next;
            bytes_sent    <= bytes_sent + 12'd1;
            state         <= DATA_LO;
          end else begin
            data_out      <= 4'd0;
            frame_seq_out <= 12'd0;
            xmit_done_out <= 1'b1;
            cnt           <= CNT_FIRST;
            state         <= IFG;
          end
        end

        IFG: begin
          data_out      <= 4'd0;
          frame_seq_out <= 12'd0;
          if (cnt == IFG_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          data_out      <= 4'd0;
          frame_seq_out <= 12'd0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_out_fsm
//  Brief    : Self-checking bench for out_fsm. A frame-level model expands each
//             descriptor into the expected per-cycle nibble/address/done trace.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_out_fsm;

  logic        clk_phy = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic [23:0] ctrl_block_in;
  logic [11:0] frame_seq_out;
  logic        xmit_done_out;
  logic [3:0]  data_out;

  logic [7:0]  mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  q_data [$];
  logic [11:0] q_seq  [$];
  logic        q_done [$];

  logic [3:0]  exp_d;
  logic [11:0] exp_s;
  logic        exp_dn;

  out_fsm dut (
    .clk_phy       (clk_phy),
    .reset         (reset),
    .data_in       (data_in),
    .ctrl_block_in (ctrl_block_in),
    .frame_seq_out (frame_seq_out),
    .xmit_done_out (xmit_done_out),
    .data_out      (data_out)
  );

  always #5 clk_phy = ~clk_phy;

  // Frame buffer with one clock of read latency.
  always @(posedge clk_phy) data_in <= mem[frame_seq_out];

  // ---------------- reference model ----------------
  function automatic void push_cycle(input logic [3:0] d, input logic [11:0] s, input logic dn);
    q_data.push_back(d);
    q_seq.push_back(s);
    q_done.push_back(dn);
  endfunction

  // Expected trace from the cycle after the descriptor is accepted:
  // 15 x 5, SFD, two nibbles per byte (address = next byte, capped at len-1),
  // then the gap with done on its first cycle.
  function automatic void model_frame(input int len);
    for (int i = 0; i < 15; i++) push_cycle(4'h5, 12'd0, 1'b0);
    push_cycle(4'hD, 12'd0, 1'b0);
    for (int b = 0; b < len; b++) begin
      int a;
      logic [7:0] byt;
      a   = (b + 1 < len - 1) ? b + 1 : len - 1;
      byt = mem[b];
      push_cycle(byt[3:0], 12'(a), 1'b0);
      push_cycle(byt[7:4], 12'(a), 1'b0);
    end
    push_cycle(4'h0, 12'd0, 1'b1);
    for (int i = 1; i < 24; i++) push_cycle(4'h0, 12'd0, 1'b0);
  endfunction

  function automatic void model_idle();
    push_cycle(4'h0, 12'd0, 1'b0);
  endfunction

  function automatic void model_clear();
    q_data.delete();
    q_seq.delete();
    q_done.delete();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset         = 1'b1;
    ctrl_block_in = 24'h000FFF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_phy);
      n_checks++;
      if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset data_out cyc %0d: got %h expected 0", c, data_out); end
      n_checks++;
      if (frame_seq_out !== 12'h000) begin n_fail++; $display("FAIL reset frame_seq_out cyc %0d: got %h expected 0", c, frame_seq_out); end
      n_checks++;
      if (xmit_done_out !== 1'b0) begin n_fail++; $display("FAIL reset xmit_done_out cyc %0d: got %b expected 0", c, xmit_done_out); end
    end
    reset = 1'b0;
    @(negedge clk_phy);
    n_checks++;
    if (data_out !== 4'h5) begin n_fail++; $display("FAIL reset_release first preamble: got %h expected 5", data_out); end
    reset         = 1'b1;
    ctrl_block_in = 24'h0;
    @(negedge clk_phy);
    n_checks++;
    if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_reapply data_out: got %h expected 0", data_out); end
    reset = 1'b0;
    @(negedge clk_phy);
    n_checks++;
    if (data_out !== 4'h0 || frame_seq_out !== 12'h0) begin
      n_fail++; $display("FAIL reset_idle: got data %h seq %h expected 0 0", data_out, frame_seq_out);
    end
  endtask

  task automatic test_preamble_sfd();
    int idx;
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    model_clear();
    model_frame(3);
    model_idle();
    ctrl_block_in = 24'h000003;
    idx = 0;
    while (q_data.size() > 0) begin
      @(negedge clk_phy);
      exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
      n_checks++;
      if (data_out !== exp_d) begin n_fail++; $display("FAIL preamble data_out idx %0d: got %h expected %h", idx, data_out, exp_d); end
      n_checks++;
      if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL preamble frame_seq_out idx %0d: got %h expected %h", idx, frame_seq_out, exp_s); end
      n_checks++;
      if (xmit_done_out !== exp_dn) begin n_fail++; $display("FAIL preamble xmit_done_out idx %0d: got %b expected %b", idx, xmit_done_out, exp_dn); end
      if (idx == 0) ctrl_block_in = 24'h0;
      idx++;
    end
  endtask

  task automatic test_nibble_order();
    int idx;
    logic [3:0] payload [6];
    int pi;
    mem[0] = 8'hAB; mem[1] = 8'hCD; mem[2] = 8'hEF;
    payload = '{4'hB, 4'hA, 4'hD, 4'hC, 4'hF, 4'hE};
    model_clear();
    model_frame(3);
    model_idle();
    ctrl_block_in = 24'h000003;
    idx = 0;
    pi  = 0;
    while (q_data.size() > 0) begin
      @(negedge clk_phy);
      exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
      n_checks++;
      if (data_out !== exp_d) begin n_fail++; $display("FAIL nibble_order data_out idx %0d: got %h expected %h", idx, data_out, exp_d); end
      n_checks++;
      if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL nibble_order frame_seq_out idx %0d: got %h expected %h", idx, frame_seq_out, exp_s); end
      n_checks++;
      if (xmit_done_out !== exp_dn) begin n_fail++; $display("FAIL nibble_order xmit_done_out idx %0d: got %b expected %b", idx, xmit_done_out, exp_dn); end
      // Literal payload order, independent of the model.
      if (idx >= 16 && idx < 22) begin
        n_checks++;
        if (data_out !== payload[pi]) begin n_fail++; $display("FAIL nibble_literal idx %0d: got %h expected %h", idx, data_out, payload[pi]); end
        pi++;
      end
      if (idx == 0) ctrl_block_in = 24'h0;
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int dones;
    int frame_cycles;
    for (int i = 0; i < 3; i++) mem[i] = 8'($urandom);
    frame_cycles = 16 + 2 * 3 + 24;
    model_clear();
    model_frame(3);
    model_idle();
    model_frame(3);
    model_idle();
    ctrl_block_in = 24'h000003;
    idx   = 0;
    dones = 0;
    while (q_data.size() > 0) begin
      @(negedge clk_phy);
      exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
      n_checks++;
      if (data_out !== exp_d) begin n_fail++; $display("FAIL back_to_back data_out idx %0d: got %h expected %h", idx, data_out, exp_d); end
      n_checks++;
      if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL back_to_back frame_seq_out idx %0d: got %h expected %h", idx, frame_seq_out, exp_s); end
      n_checks++;
      if (xmit_done_out !== exp_dn) begin n_fail++; $display("FAIL back_to_back xmit_done_out idx %0d: got %b expected %b", idx, xmit_done_out, exp_dn); end
      if (xmit_done_out === 1'b1) dones++;
      if (idx == frame_cycles + 1) ctrl_block_in = 24'h0;
      idx++;
    end
    n_checks++;
    if (dones != 2) begin n_fail++; $display("FAIL back_to_back done_count: got %0d expected 2", dones); end
  endtask

  task automatic test_long_frame();
    int idx;
    int dones;
    logic [11:0] max_seq;
    for (int i = 0; i < 4096; i++) mem[i] = 8'hAB;
    model_clear();
    model_frame(4095);
    model_idle();
    ctrl_block_in = 24'h000FFF;
    idx     = 0;
    dones   = 0;
    max_seq = 12'h0;
    while (q_data.size() > 0) begin
      @(negedge clk_phy);
      exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
      n_checks++;
      if (data_out !== exp_d) begin n_fail++; $display("FAIL long_frame data_out idx %0d: got %h expected %h", idx, data_out, exp_d); end
      n_checks++;
      if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL long_frame frame_seq_out idx %0d: got %h expected %h", idx, frame_seq_out, exp_s); end
      n_checks++;
      if (xmit_done_out !== exp_dn) begin n_fail++; $display("FAIL long_frame xmit_done_out idx %0d: got %b expected %b", idx, xmit_done_out, exp_dn); end
      if (xmit_done_out === 1'b1) dones++;
      if (frame_seq_out > max_seq) max_seq = frame_seq_out;
      if (idx == 0) ctrl_block_in = 24'h0;
      idx++;
    end
    n_checks++;
    if (dones != 1) begin n_fail++; $display("FAIL long_frame done_count: got %0d expected 1", dones); end
    n_checks++;
    if (max_seq !== 12'hFFE) begin n_fail++; $display("FAIL long_frame seq_saturation: got %h expected ffe", max_seq); end
  endtask

  // Random lengths/bytes; descriptor scrambled while busy to confirm it is ignored.
  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int len;
      int total;
      int idx;
      len = (f == 0) ? 1 : int'($urandom_range(2, 24));
      for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
      for (int i = len; i < len + 4; i++) mem[i] = 8'($urandom);
      total = 16 + 2 * len + 24;
      model_clear();
      model_frame(len);
      model_idle();
      ctrl_block_in = {12'($urandom), 12'(len)};
      idx = 0;
      while (q_data.size() > 0) begin
        @(negedge clk_phy);
        exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
        n_checks++;
        if (data_out !== exp_d) begin n_fail++; $display("FAIL random f%0d len %0d data_out idx %0d: got %h expected %h", f, len, idx, data_out, exp_d); end
        n_checks++;
        if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL random f%0d len %0d frame_seq_out idx %0d: got %h expected %h", f, len, idx, frame_seq_out, exp_s); end
        n_checks++;
        if (xmit_done_out !== exp_dn) begin n_fail++; $display("FAIL random f%0d len %0d xmit_done_out idx %0d: got %b expected %b", f, len, idx, xmit_done_out, exp_dn); end
        if (idx < total - 1) ctrl_block_in = {12'($urandom), 12'($urandom_range(1, 4095))};
        else                 ctrl_block_in = 24'h0;
        idx++;
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    int idx;
    mem[0] = 8'hAB; mem[1] = 8'hCD; mem[2] = 8'hEF;
    model_clear();
    model_frame(3);
    ctrl_block_in = 24'h000003;
    // Cycles 0..19 reach the high nibble of byte 1.
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_phy);
      exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
      n_checks++;
      if (data_out !== exp_d) begin n_fail++; $display("FAIL mid_reset pre data_out idx %0d: got %h expected %h", c, data_out, exp_d); end
      n_checks++;
      if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL mid_reset pre frame_seq_out idx %0d: got %h expected %h", c, frame_seq_out, exp_s); end
    end
    reset = 1'b1;
    @(negedge clk_phy);
    n_checks++;
    if (data_out !== 4'h0) begin n_fail++; $display("FAIL mid_reset data_out: got %h expected 0", data_out); end
    n_checks++;
    if (frame_seq_out !== 12'h0) begin n_fail++; $display("FAIL mid_reset frame_seq_out: got %h expected 0", frame_seq_out); end
    n_checks++;
    if (xmit_done_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset xmit_done_out: got %b expected 0", xmit_done_out); end
    reset = 1'b0;
    model_clear();
    model_frame(3);
    model_idle();
    idx = 0;
    while (q_data.size() > 0) begin
      @(negedge clk_phy);
      exp_d = q_data.pop_front(); exp_s = q_seq.pop_front(); exp_dn = q_done.pop_front();
      n_checks++;
      if (data_out !== exp_d) begin n_fail++; $display("FAIL mid_reset restart data_out idx %0d: got %h expected %h", idx, data_out, exp_d); end
      n_checks++;
      if (frame_seq_out !== exp_s) begin n_fail++; $display("FAIL mid_reset restart frame_seq_out idx %0d: got %h expected %h", idx, frame_seq_out, exp_s); end
      n_checks++;
      if (xmit_done_out !== exp_dn) begin n_fail++; $display("FAIL mid_reset restart xmit_done_out idx %0d: got %b expected %b", idx, xmit_done_out, exp_dn); end
      if (idx == 0) ctrl_block_in = 24'h0;
      idx++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_block_in = 24'h0;
    test_reset();
    test_preamble_sfd();
    test_nibble_order();
    test_back_to_back();
    test_random_frames();
    test_mid_frame_reset();
    test_long_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
